// File: rtl/jk_pkg.sv
// Command encoding and next-state function shared by the JK flop RTL and its bench.
// Pure definitions, no logic of its own.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TOG  = 2'b11;

    // An unknown j or k matches no command, so the bit goes X instead of being masked.
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic nxt;
        case ({j, k})
            JK_HOLD: nxt = q;
            JK_CLR:  nxt = 1'b0;
            JK_SET:  nxt = 1'b1;
            JK_TOG:  nxt = ~q;
            default: nxt = 1'bx;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_flop_if.sv
// j/k command and q/qn state bundle for a WIDTH-bit JK flop bank.
// The master drives commands and observes state; the slave is the flop bank.
interface jk_flop_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;

    modport master (output j, output k, input  q, input  qn);
    modport slave  (input  j, input  k, output q, output qn);
endinterface

// File: rtl/jk_flop_cell.sv
// Single-bit JK flop with asynchronous active-low reset to RST_VAL.
// Latency: 1 clk from j/k to q; no backpressure, a command is taken every edge.
module jk_cell
    import jk_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RST_VAL;
        end else begin
            q <= jk_next(q, j, k);
        end
    end

endmodule

// File: rtl/jk_flop.sv
// WIDTH independent JK cells on one clock/reset; qn is the inverse of the registered q.
// Latency: 1 clk from j/k to q/qn; no backpressure, a command is taken every edge.
module jk_flop
    import jk_pkg::*;
#(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    // Port order is fixed so legacy positional (q, j, k, clk) instances still bind.
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             clk,
    input  logic             rst_n,
    output logic [WIDTH-1:0] qn
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell #(
            .RST_VAL (RST_VAL[i])
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j[i]),
            .k     (k[i]),
            .q     (q[i])
        );
    end

    assign qn = ~q;

endmodule

// File: tb/tb_jk_flop.sv
// Directed bench for jk_flop: one 1-bit bank, one 4-bit bank, one 4-bit bank with RST_VAL=1010.
module tb_jk_flop;
    import jk_pkg::*;

    logic clk;
    logic rst1, rst4, rst4r;
    int   checks   = 0;
    int   failures = 0;

    logic [3:0] sb_exp[$];

    jk_flop_if #(.WIDTH(1)) if1 ();
    jk_flop_if #(.WIDTH(4)) if4 ();
    jk_flop_if #(.WIDTH(4)) if4r ();

    jk_flop #(.WIDTH(1)) u1 (
        .q(if1.q), .j(if1.j), .k(if1.k), .clk(clk), .rst_n(rst1), .qn(if1.qn)
    );
    jk_flop #(.WIDTH(4)) u4 (
        .q(if4.q), .j(if4.j), .k(if4.k), .clk(clk), .rst_n(rst4), .qn(if4.qn)
    );
    jk_flop #(.WIDTH(4), .RST_VAL(4'b1010)) u4r (
        .q(if4r.q), .j(if4r.j), .k(if4r.k), .clk(clk), .rst_n(rst4r), .qn(if4r.qn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_check(input string tag, input logic [3:0] obs);
        logic [3:0] exp;
        if (sb_exp.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: got %b expected <scoreboard entry>", tag, obs);
        end else begin
            exp = sb_exp.pop_front();
            check(tag, obs, exp);
        end
    endtask

    // 1-bit step: drive command, record expectation, clock once, compare q and qn.
    task automatic step1(input string tag, input logic [1:0] cmd, input logic e);
        {if1.j, if1.k} = cmd;
        sb_exp.push_back({3'b000, e});
        tick();
        sb_check(tag, {3'b000, if1.q});
        check({tag, "_qn"}, {3'b000, if1.qn}, {3'b000, ~e});
    endtask

    task automatic step4(input string tag, input logic [3:0] jv, input logic [3:0] kv,
                         input logic [3:0] e);
        if4.j = jv;
        if4.k = kv;
        sb_exp.push_back(e);
        tick();
        sb_check(tag, if4.q);
    endtask

    initial begin
        rst1 = 1'b0; rst4 = 1'b0; rst4r = 1'b0;
        if1.j = '0; if1.k = '0;
        if4.j = '0; if4.k = '0;
        if4r.j = '0; if4r.k = '0;
        #12;
        check("rst_q1",   {3'b000, if1.q},  4'b0000);
        check("rst_qn1",  {3'b000, if1.qn}, 4'b0001);
        check("rst_q4",   if4.q,  4'b0000);
        check("rst_q4r",  if4r.q, 4'b1010);
        check("rst_qn4r", if4r.qn, 4'b0101);
        rst1 = 1'b1; rst4 = 1'b1; rst4r = 1'b1;

        // Asynchronous reset with q=1, mid-cycle.
        step1("set_pre", JK_SET, 1'b1);
        #3 rst1 = 1'b0;
        #1;
        check("async_q",  {3'b000, if1.q},  4'b0000);
        check("async_qn", {3'b000, if1.qn}, 4'b0001);
        if1.j = 1'b1; if1.k = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            check("rst_hold_edges", {3'b000, if1.q}, 4'b0000);
        end
        #4 rst1 = 1'b1;
        #1;
        check("release_clean", {3'b000, if1.q}, 4'b0000);
        // Re-align to one ns after a rising edge for the scoreboard steps.
        @(posedge clk); #1;
        sb_exp.delete();

        // Clear / set / hold.
        step1("clr",   JK_CLR,  1'b0);
        step1("set",   JK_SET,  1'b1);
        step1("hold0", JK_HOLD, 1'b1);
        step1("hold1", JK_HOLD, 1'b1);

        // Toggle sequence from 0.
        step1("tog_clr", JK_CLR, 1'b0);
        step1("tog1", JK_TOG, 1'b1);
        step1("tog2", JK_TOG, 1'b0);
        step1("tog3", JK_TOG, 1'b1);
        step1("tog4", JK_TOG, 1'b0);

        // Bitwise independence: load 0011, then mixed commands.
        step4("load0011", 4'b0011, 4'b1100, 4'b0011);
        step4("mixed",    4'b0101, 4'b0110, 4'b0101);

        // X on one command bit poisons only that bit.
        step4("x_bit1", 4'b00x0, 4'b0000, 4'b01x1);
        step4("x_recover", 4'b0101, 4'b1010, 4'b0101);

        // Reset in the same timestep as a rising edge, q=0, j=1.
        if1.j = 1'b1; if1.k = 1'b0;
        @(posedge clk);
        rst1 = 1'b0;
        #3 rst1 = 1'b1;
        #1;
        check("coinc_q", {3'b000, if1.q}, 4'b0000);
        @(posedge clk); #1;
        check("coinc_next", {3'b000, if1.q}, 4'b0001);

        // Non-zero RST_VAL re-applied after the bank has been cleared.
        if4r.j = 4'b0000; if4r.k = 4'b1111;
        tick();
        check("rv_cleared", if4r.q, 4'b0000);
        #2 rst4r = 1'b0;
        #1;
        check("rv_q",  if4r.q,  4'b1010);
        check("rv_qn", if4r.qn, 4'b0101);
        rst4r = 1'b1;

        check("sb_drained", 4'(sb_exp.size()), 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
